note_seq_gen: RTL and testbench

- Transmit-side counterpart of the note-word classifier FSM.
- Takes a requested word type (adj / comp / adv), a path variant and two free leading notes.
- Plays the matching note sequence onto the classifier's input interface: 4-bit note code plus an ok strobe, ending with a null note.
- Used as the stimulus source / "speaker" driving the classifier in the top level and in self-checking benches.

---
 rtl/note_seq_gen_pkg.sv | 71 +++++++
 rtl/note_seq_rom.sv | 62 ++++++
 rtl/note_seq_gen.sv | 174 +++++++++++++++++
 tb/tb_note_seq_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_gen_pkg.sv
// ============================================================================
// Module      : note_seq_gen_pkg
// Description : Shared definitions for the note-word transmitter and the
//               note-word classifier: note codes, word-type codes, sequence
//               lengths and small helper functions.
// Contents    : note_t, NULL_NOTE1/2, NOTE_DO..NOTE_SI, NOTE_DO_M..NOTE_SI_M,
//               TIPO_SEM/ADJ/COMP/ADV, SEQ_LEN_SHORT/LONG, IDX_W,
//               is_null_note(), seq_len()
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package note_seq_gen_pkg;

  typedef logic [3:0] note_t;

  // Null notes: both codes mean "no note"; the transmitter only ever emits 0.
  localparam note_t NULL_NOTE1 = 4'd0;
  localparam note_t NULL_NOTE2 = 4'd8;

  // Natural notes
  localparam note_t NOTE_DO  = 4'd1;
  localparam note_t NOTE_RE  = 4'd2;
  localparam note_t NOTE_MI  = 4'd3;
  localparam note_t NOTE_FA  = 4'd4;
  localparam note_t NOTE_SOL = 4'd5;
  localparam note_t NOTE_LA  = 4'd6;
  localparam note_t NOTE_SI  = 4'd7;

  // Minor notes
  localparam note_t NOTE_DO_M  = 4'd9;
  localparam note_t NOTE_RE_M  = 4'd10;
  localparam note_t NOTE_MI_M  = 4'd11;
  localparam note_t NOTE_FA_M  = 4'd12;
  localparam note_t NOTE_SOL_M = 4'd13;
  localparam note_t NOTE_LA_M  = 4'd14;
  localparam note_t NOTE_SI_M  = 4'd15;

  // Word types
  localparam logic [1:0] TIPO_SEM  = 2'b00;
  localparam logic [1:0] TIPO_ADJ  = 2'b01;
  localparam logic [1:0] TIPO_COMP = 2'b10;
  localparam logic [1:0] TIPO_ADV  = 2'b11;

  // Sequence lengths (including the trailing null note)
  localparam int SEQ_LEN_SHORT = 4;
  localparam int SEQ_LEN_LONG  = 5;

  // Symbol index width, wide enough to hold SEQ_LEN_LONG
  localparam int IDX_W = 3;

  function automatic logic is_null_note(input note_t n);
    return (n == NULL_NOTE1) || (n == NULL_NOTE2);
  endfunction

  // Number of symbols played for a word type; sem_tipo maps to a single
  // null symbol so that a lookup on it is harmless.
  function automatic logic [IDX_W-1:0] seq_len(input logic [1:0] t);
    logic [IDX_W-1:0] len;
    case (t)
      TIPO_ADJ:  len = IDX_W'(SEQ_LEN_SHORT);
      TIPO_COMP: len = IDX_W'(SEQ_LEN_LONG);
      TIPO_ADV:  len = IDX_W'(SEQ_LEN_LONG);
      default:   len = IDX_W'(1);
    endcase
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_seq_rom.sv
// ============================================================================
// Module      : note_seq_rom
// Description : Combinational note-sequence table. Returns the note code to
//               play at a given symbol index, and whether that index is the
//               final (null) symbol of the sequence.
// Ports       : tipo     in  2  word type
//               variante in  1  path select (0 = La path, 1 = Si_m path)
//               index    in  3  symbol index
//               nota1    in  4  first free note
//               nota2    in  4  second free note
//               note     out 4  note code for this index
//               last     out 1  index is the final symbol
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_seq_rom
  import note_seq_gen_pkg::*;
(
  input  logic [1:0]       tipo,
  input  logic             variante,
  input  logic [IDX_W-1:0] index,
  input  note_t            nota1,
  input  note_t            nota2,
  output note_t            note,
  output logic             last
);

  logic [IDX_W-1:0] len;

  always_comb begin
    len  = seq_len(tipo);
    note = NULL_NOTE1;
    // Indices beyond the end also report last so a stray lookup terminates.
    last = (index >= (len - IDX_W'(1)));

    if (tipo != TIPO_SEM) begin
      case (index)
        IDX_W'(0): note = nota1;
        IDX_W'(1): note = nota2;
        IDX_W'(2): begin
          // adv always passes through La; adj/comp pick by variant
          if (tipo == TIPO_ADV)
            note = NOTE_LA;
          else
            note = variante ? NOTE_SI_M : NOTE_LA;
        end
        IDX_W'(3): begin
          case (tipo)
            TIPO_COMP: note = variante ? NOTE_RE : NOTE_DO;
            TIPO_ADV:  note = NOTE_SI_M;
            default:   note = NULL_NOTE1;
          endcase
        end
        default: note = NULL_NOTE1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/note_seq_gen.sv
// ============================================================================
// Module      : note_seq_gen
// Description : Note-word transmitter. On an accepted request it plays the
//               note sequence for the requested word type, one symbol per
//               2*HALF cycles: nota is held for the whole symbol and ok is
//               low for HALF cycles then high for HALF cycles, so the
//               receiver captures each note on the ok rising edge.
// Parameters  : HALF      cycles per half symbol period (>= 1)
// Ports       : clk       in  1  system clock
//               reset     in  1  asynchronous active-high reset
//               start     in  1  request strobe, sampled only in IDLE
//               tipo      in  2  word type
//               variante  in  1  path select (ignored for adv)
//               nota1     in  4  first free note
//               nota2     in  4  second free note
//               nota      out 4  note code to the receiver
//               ok        out 1  capture strobe
//               busy      out 1  sequence in progress
//               done      out 1  one-cycle completion pulse
//               erro      out 1  one-cycle rejection pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_seq_gen
  import note_seq_gen_pkg::*;
#(
  parameter int HALF = 2
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] tipo,
  input  logic       variante,
  input  logic [3:0] nota1,
  input  logic [3:0] nota2,
  output logic [3:0] nota,
  output logic       ok,
  output logic       busy,
  output logic       done,
  output logic       erro
);

  localparam int               CNT_W    = (2 * HALF > 2) ? $clog2(2 * HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * HALF - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       tipo_q;
  logic             var_q;
  note_t            nota1_q;
  note_t            nota2_q;
  logic [IDX_W-1:0] index;
  logic [CNT_W-1:0] cnt;
  logic             last_q;   // symbol currently on the wire is the final one

  logic             req_valid;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       rom_tipo;
  logic             rom_var;
  note_t            rom_n1;
  note_t            rom_n2;
  logic [IDX_W-1:0] rom_index;
  note_t            rom_note;
  logic             rom_last;

  assign req_valid = (tipo != TIPO_SEM) && !is_null_note(nota1) && !is_null_note(nota2);
  assign cnt_inc   = cnt + CNT_W'(1);

  // The table is addressed with the symbol about to be loaded: in IDLE that
  // is symbol 0 of the incoming request (fields not yet latched), in SEND it
  // is the next symbol of the latched request. This lets nota be a register
  // that changes on exactly the edge where the index advances.
  always_comb begin
    if (state == ST_IDLE) begin
      rom_tipo  = tipo;
      rom_var   = variante;
      rom_n1    = nota1;
      rom_n2    = nota2;
      rom_index = '0;
    end else begin
      rom_tipo  = tipo_q;
      rom_var   = var_q;
      rom_n1    = nota1_q;
      rom_n2    = nota2_q;
      rom_index = index + IDX_W'(1);
    end
  end

  note_seq_rom u_rom (
    .tipo     (rom_tipo),
    .variante (rom_var),
    .index    (rom_index),
    .nota1    (rom_n1),
    .nota2    (rom_n2),
    .note     (rom_note),
    .last     (rom_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      tipo_q  <= TIPO_SEM;
      var_q   <= 1'b0;
      nota1_q <= NULL_NOTE1;
      nota2_q <= NULL_NOTE1;
      index   <= '0;
      cnt     <= '0;
      last_q  <= 1'b0;
      nota    <= NULL_NOTE1;
      ok      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      erro    <= 1'b0;
    end else begin
      done <= 1'b0;
      erro <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (req_valid) begin
              tipo_q  <= tipo;
              var_q   <= variante;
              nota1_q <= nota1;
              nota2_q <= nota2;
              index   <= '0;
              cnt     <= '0;
              nota    <= rom_note;
              last_q  <= rom_last;
              ok      <= 1'b0;
              busy    <= 1'b1;
              state   <= ST_SEND;
            end else begin
              erro <= 1'b1;
            end
          end
        end

        ST_SEND: begin
          if (cnt == CNT_LAST) begin
            // Symbol boundary: ok falls on the same edge the note changes.
            cnt <= '0;
            ok  <= 1'b0;
            if (last_q) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              nota  <= NULL_NOTE1;
              index <= '0;
              done  <= 1'b1;
            end else begin
              index  <= index + IDX_W'(1);
              nota   <= rom_note;
              last_q <= rom_last;
            end
          end else begin
            cnt <= cnt_inc;
            ok  <= (cnt_inc >= CNT_HALF);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_note_seq_gen.sv
// ============================================================================
// Module      : tb_note_seq_gen
// Description : Self-checking bench for note_seq_gen. A behavioural model
//               tracks time since accept and derives the expected outputs
//               from the sequence tables; directed cases pin exact notes,
//               busy lengths and pulse timing, then random traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_seq_gen;

  localparam int HALF = 2;
  localparam int PER  = 2 * HALF;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] tipo;
  logic       variante;
  logic [3:0] nota1;
  logic [3:0] nota2;
  logic [3:0] nota;
  logic       ok;
  logic       busy;
  logic       done;
  logic       erro;

  always #5 clk = ~clk;

  note_seq_gen #(.HALF(HALF)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tipo     (tipo),
    .variante (variante),
    .nota1    (nota1),
    .nota2    (nota2),
    .nota     (nota),
    .ok       (ok),
    .busy     (busy),
    .done     (done),
    .erro     (erro)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit m_active = 0;
  int m_t      = 0;
  int m_len    = 0;
  int m_seq[5];
  bit m_done   = 0;
  bit m_erro   = 0;

  function automatic bit is_null(input logic [3:0] n);
    return (n == 4'd0) || (n == 4'd8);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_t = 0; m_len = 0; m_done = 0; m_erro = 0;
    end else begin
      m_done = 0;
      m_erro = 0;
      if (m_active) begin
        m_t++;
        if (m_t == m_len * PER) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (start === 1'b1) begin
        if (tipo == 2'b00 || is_null(nota1) || is_null(nota2)) begin
          m_erro = 1;
        end else begin
          m_active = 1;
          m_t      = 0;
          m_seq[0] = nota1;
          m_seq[1] = nota2;
          m_seq[4] = 0;
          case (tipo)
            2'b01: begin m_len = 4; m_seq[2] = variante ? 15 : 6; m_seq[3] = 0; end
            2'b10: begin m_len = 5; m_seq[2] = variante ? 15 : 6; m_seq[3] = variante ? 2 : 1; end
            default: begin m_len = 5; m_seq[2] = 6; m_seq[3] = 15; end
          endcase
        end
      end
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("nota", nota, m_active ? m_seq[m_t / PER] : 0);
      check("ok",   ok,   (m_active && (m_t % PER) >= HALF) ? 1 : 0);
      check("busy", busy, m_active ? 1 : 0);
      check("done", done, m_done ? 1 : 0);
      check("erro", erro, m_erro ? 1 : 0);
    end
  end

  // Notes the receiver would capture, and busy-cycle counter
  int cap_q[$];
  int busy_cycles = 0;

  always @(posedge ok) begin
    if (!reset) begin
      cap_q.push_back(int'(nota));
      check("ok_rise_while_busy", busy, 1);
    end
  end

  always @(negedge clk) if (busy === 1'b1) busy_cycles++;

  // ---------------- stimulus helpers ----------------
  task automatic req(input logic [1:0] t, input logic v, input logic [3:0] a, input logic [3:0] b);
    @(posedge clk); #1;
    tipo = t; variante = v; nota1 = a; nota2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the negedge count (after the accept edge) at which done is seen
  task automatic wait_done(output int at);
    at = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin at = i; break; end
    end
    if (at == 0) check("done_timeout", 0, 1);
  endtask

  task automatic expect_caps(input string name, input int e0, input int e1, input int e2,
                             input int e3, input int e4, input int n);
    int e[5];
    e = '{e0, e1, e2, e3, e4};
    check({name, "_count"}, cap_q.size(), n);
    for (int i = 0; i < n && i < cap_q.size(); i++)
      check($sformatf("%s_note%0d", name, i), cap_q[i], e[i]);
  endtask

  int at;

  initial begin
    reset = 1'b1; start = 1'b0; tipo = 2'b00; variante = 1'b0; nota1 = 4'd0; nota2 = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_nota", nota, 0);
    check("rst_ok",   ok,   0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_erro", erro, 0);
    @(negedge clk); reset = 1'b0; chk_en = 1;

    // 1: adj, La path
    cap_q.delete(); busy_cycles = 0;
    req(2'b01, 1'b0, 4'd3, 4'd5);
    wait_done(at);
    check("t1_done_at", at, 17);
    check("t1_busy_cycles", busy_cycles, 16);
    expect_caps("t1", 3, 5, 6, 0, 0, 4);

    // 2: comp, Si_m path
    cap_q.delete(); busy_cycles = 0;
    req(2'b10, 1'b1, 4'd1, 4'd7);
    wait_done(at);
    check("t2_done_at", at, 21);
    check("t2_busy_cycles", busy_cycles, 20);
    expect_caps("t2", 1, 7, 15, 2, 0, 5);

    // 3: adv, variant ignored
    cap_q.delete();
    req(2'b11, 1'b1, 4'd9, 4'd4);
    wait_done(at);
    expect_caps("t3", 9, 4, 6, 15, 0, 5);

    // 4: rejected requests
    cap_q.delete();
    req(2'b00, 1'b0, 4'd3, 4'd5);
    @(negedge clk);
    check("t4a_erro", erro, 1);
    check("t4a_busy", busy, 0);
    @(negedge clk);
    check("t4a_erro_off", erro, 0);
    req(2'b01, 1'b0, 4'd3, 4'd8);
    @(negedge clk);
    check("t4b_erro", erro, 1);
    repeat (4) @(negedge clk);
    check("t4_no_ok", cap_q.size(), 0);

    // 5: start mid-sequence ignored, then start in the done cycle
    cap_q.delete();
    req(2'b10, 1'b0, 4'd2, 4'd11);
    repeat (5) @(posedge clk);
    #1; tipo = 2'b11; nota1 = 4'd7; nota2 = 4'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(at);
    expect_caps("t5a", 2, 11, 6, 1, 0, 5);
    cap_q.delete();
    tipo = 2'b01; variante = 1'b1; nota1 = 4'd12; nota2 = 4'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("t5b_busy_no_gap", busy, 1);
    wait_done(at);
    expect_caps("t5b", 12, 4, 15, 0, 0, 4);

    // 6: async reset during the third symbol while ok is high
    cap_q.delete();
    req(2'b10, 1'b0, 4'd5, 4'd6);
    repeat (2 * PER + HALF + 1) @(negedge clk);
    check("t6_ok_before", ok, 1);
    check("t6_nota_before", nota, 6);
    #2 reset = 1'b1;
    #1;
    check("t6_ok_rst",   ok,   0);
    check("t6_nota_rst", nota, 0);
    check("t6_busy_rst", busy, 0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    cap_q.delete();
    req(2'b11, 1'b0, 4'd1, 4'd13);
    wait_done(at);
    expect_caps("t6", 1, 13, 6, 15, 0, 5);

    // Random traffic: model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start    = ($urandom_range(0, 5) == 0);
      tipo     = 2'($urandom_range(0, 3));
      variante = 1'($urandom_range(0, 1));
      nota1    = 4'($urandom_range(0, 15));
      nota2    = 4'($urandom_range(0, 15));
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("final_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
